// File: rtl/aes_pkg.sv
// Shared AES constants, the padder state encoding and a tkeep popcount helper.
package aes_pkg;

    localparam int AES_BLOCK_SIZE    = 128;
    localparam int AES_BLOCK_BYTES   = 16;
    localparam int AES_256_KEY_BYTES = 32;
    localparam int AES_IV_BYTES      = 16;

    typedef enum logic [2:0] {
        ST_HEADER  = 3'b001,
        ST_PAYLOAD = 3'b010,
        ST_PAD     = 3'b100
    } state_e;

    // Number of set bits in a (zero-extended) tkeep of up to 16 lanes.
    function automatic logic [4:0] popcount16(input logic [15:0] keep);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle with a one-bit tuser carrying the cipher direction.
interface axis_if #(
    parameter int AXIS_WIDTH = 8
) ();
    logic [AXIS_WIDTH-1:0]   tdata;
    logic [AXIS_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tuser;

    modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/aes_pkcs7_fill.sv
// Combinational PKCS#7 lane filler: byte lanes absent from keep_i take the pad byte.
module aes_pkcs7_fill #(
    parameter int AXIS_WIDTH = 8
) (
    input  logic [AXIS_WIDTH-1:0]   data_i,
    input  logic [AXIS_WIDTH/8-1:0] keep_i,
    input  logic [7:0]              pad_i,
    output logic [AXIS_WIDTH-1:0]   data_o
);

    localparam int BPB = AXIS_WIDTH / 8;

    // Per-lane select between the original byte and the pad value.
    always_comb begin
        data_o = data_i;
        for (int i = 0; i < BPB; i++) begin
            if (keep_i[i]) begin
                data_o[i*8 +: 8] = data_i[i*8 +: 8];
            end else begin
                data_o[i*8 +: 8] = pad_i;
            end
        end
    end

endmodule

// File: rtl/aes_cbc_pkcs7_padder.sv
// Feeds key, IV and payload to the AES-256-CBC core as a 16-byte aligned stream,
// appending PKCS#7 padding on encrypt and length-checking on decrypt.
module aes_cbc_pkcs7_padder
    import aes_pkg::*;
#(
    parameter int AXIS_WIDTH = 8
) (
    input  logic   Clk,
    input  logic   Rst,
    axis_if.slave  S_axis,
    axis_if.master M_axis,
    output logic   Err
);

    localparam int             BPB       = AXIS_WIDTH / 8;
    localparam int             HDR_BEATS = (AES_256_KEY_BYTES + AES_IV_BYTES) / BPB;
    localparam logic [5:0]     HDR_LAST  = 6'(HDR_BEATS - 1);
    localparam logic [4:0]     BPB5      = 5'(BPB);
    localparam logic [4:0]     BLK5      = 5'(AES_BLOCK_BYTES);
    localparam logic [BPB-1:0] KEEP_ALL  = {BPB{1'b1}};

    state_e                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [5:0]              hdr_cnt_q, hdr_cnt_d;
    logic [3:0]              off_q, off_d;
    logic [4:0]              pad_q, pad_d;
    logic                    tvalid_q, tvalid_d;
    logic [AXIS_WIDTH-1:0]   tdata_q, tdata_d;
    logic [BPB-1:0]          tkeep_q, tkeep_d;
    logic                    tlast_q, tlast_d;
    logic                    tuser_q, tuser_d;
    logic                    err_q, err_d;

    logic                    out_ready_s;
    logic                    s_tready_s;
    logic                    in_fire_s;
    logic                    hdr_first_s;
    logic                    hdr_last_s;
    logic                    keep_full_s;
    logic [4:0]              n_s;
    logic [4:0]              pay_sum_s;
    logic [4:0]              off_step_s;
    logic                    pad_end_s;
    logic                    blk_done_s;
    logic [4:0]              pad_calc_s;
    logic [7:0]              pad_byte_s;
    logic [AXIS_WIDTH-1:0]   filled_s;

    assign out_ready_s = ~tvalid_q | M_axis.tready;
    assign s_tready_s  = out_ready_s & (state_q != ST_PAD);
    assign in_fire_s   = S_axis.tvalid & s_tready_s;
    assign hdr_first_s = (hdr_cnt_q == 6'd0);
    assign hdr_last_s  = (hdr_cnt_q == HDR_LAST);
    assign keep_full_s = &S_axis.tkeep;
    assign n_s         = popcount16(16'(S_axis.tkeep));
    assign pay_sum_s   = {1'b0, off_q} + n_s;
    assign off_step_s  = {1'b0, off_q} + BPB5;
    // >= rather than == so a misaligned offset after a framing error still terminates padding.
    assign pad_end_s   = (off_step_s >= BLK5);
    assign blk_done_s  = (off_step_s == BLK5) & (n_s < BPB5);
    assign pad_calc_s  = BLK5 - {1'b0, pay_sum_s[3:0]};
    assign pad_byte_s  = {3'b000, pad_q};

    aes_pkcs7_fill #(
        .AXIS_WIDTH(AXIS_WIDTH)
    ) u_fill (
        .data_i(S_axis.tdata),
        .keep_i(S_axis.tkeep),
        .pad_i ({3'b000, pad_calc_s}),
        .data_o(filled_s)
    );

    assign S_axis.tready = s_tready_s;
    assign M_axis.tvalid = tvalid_q;
    assign M_axis.tdata  = tdata_q;
    assign M_axis.tkeep  = tkeep_q;
    assign M_axis.tlast  = tlast_q;
    assign M_axis.tuser  = tuser_q;
    assign Err           = err_q;

    // State, counters and the registered output stage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_HEADER;
            mode_q    <= 1'b0;
            hdr_cnt_q <= 6'd0;
            off_q     <= 4'd0;
            pad_q     <= 5'd0;
            tvalid_q  <= 1'b0;
            tdata_q   <= {AXIS_WIDTH{1'b0}};
            tkeep_q   <= {BPB{1'b0}};
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            hdr_cnt_q <= hdr_cnt_d;
            off_q     <= off_d;
            pad_q     <= pad_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            err_q     <= err_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        hdr_cnt_d = hdr_cnt_q;
        off_d     = off_q;
        pad_d     = pad_q;
        case (state_q)
            ST_HEADER: begin
                if (in_fire_s) begin
                    if (hdr_first_s) begin
                        mode_d = S_axis.tuser;
                    end else begin
                        mode_d = mode_q;
                    end
                    if (S_axis.tlast && !hdr_last_s) begin
                        hdr_cnt_d = 6'd0;
                    end else if (hdr_last_s) begin
                        hdr_cnt_d = 6'd0;
                        off_d     = 4'd0;
                        if (!S_axis.tlast) begin
                            state_d = ST_PAYLOAD;
                        end else if (mode_q) begin
                            state_d = ST_PAD;
                            pad_d   = BLK5;
                        end else begin
                            state_d = ST_HEADER;
                        end
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 6'd1;
                    end
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (in_fire_s) begin
                    off_d = off_step_s[3:0];
                    if (!S_axis.tlast) begin
                        state_d = ST_PAYLOAD;
                    end else if (mode_q && !blk_done_s) begin
                        state_d = ST_PAD;
                        pad_d   = pad_calc_s;
                    end else begin
                        state_d = ST_HEADER;
                        off_d   = 4'd0;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAD: begin
                if (out_ready_s) begin
                    if (pad_end_s) begin
                        state_d = ST_HEADER;
                        off_d   = 4'd0;
                    end else begin
                        off_d = off_step_s[3:0];
                    end
                end else begin
                    state_d = ST_PAD;
                end
            end
            default: begin
                state_d   = ST_HEADER;
                hdr_cnt_d = 6'd0;
                off_d     = 4'd0;
            end
        endcase
    end

    // Output beat and framing-error pulse for the next cycle.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        err_d    = 1'b0;
        if (out_ready_s) begin
            tvalid_d = 1'b0;
            case (state_q)
                ST_HEADER: begin
                    if (in_fire_s && !(S_axis.tlast && !hdr_last_s)) begin
                        tvalid_d = 1'b1;
                        tdata_d  = S_axis.tdata;
                        tkeep_d  = S_axis.tkeep;
                        tlast_d  = S_axis.tlast & ~mode_q;
                        tuser_d  = hdr_first_s ? S_axis.tuser : mode_q;
                        err_d    = S_axis.tlast & ~mode_q;
                    end else begin
                        err_d = in_fire_s;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_fire_s) begin
                        tvalid_d = 1'b1;
                        tuser_d  = mode_q;
                        if (mode_q && S_axis.tlast) begin
                            tdata_d = filled_s;
                            tkeep_d = KEEP_ALL;
                            tlast_d = blk_done_s;
                        end else begin
                            tdata_d = S_axis.tdata;
                            tkeep_d = S_axis.tkeep;
                            tlast_d = S_axis.tlast;
                            if (!mode_q && S_axis.tlast) begin
                                err_d = (pay_sum_s != BLK5);
                            end else begin
                                err_d = ~keep_full_s;
                            end
                        end
                    end else begin
                        tvalid_d = 1'b0;
                    end
                end
                ST_PAD: begin
                    tvalid_d = 1'b1;
                    tdata_d  = {BPB{pad_byte_s}};
                    tkeep_d  = KEEP_ALL;
                    tlast_d  = pad_end_s;
                    tuser_d  = mode_q;
                end
                default: begin
                    tvalid_d = 1'b0;
                end
            endcase
        end else begin
            tvalid_d = tvalid_q;
        end
    end

endmodule

// File: tb/tb_aes_cbc_pkcs7_padder.sv
// Directed bench for the PKCS#7 padder at 8-bit and 32-bit stream widths.
module tb_aes_cbc_pkcs7_padder;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    axis_if #(.AXIS_WIDTH(8))  s8  ();
    axis_if #(.AXIS_WIDTH(8))  m8  ();
    axis_if #(.AXIS_WIDTH(32)) s32 ();
    axis_if #(.AXIS_WIDTH(32)) m32 ();
    logic err8, err32;

    aes_cbc_pkcs7_padder #(.AXIS_WIDTH(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .S_axis(s8), .M_axis(m8), .Err(err8)
    );
    aes_cbc_pkcs7_padder #(.AXIS_WIDTH(32)) dut32 (
        .Clk(Clk), .Rst(Rst), .S_axis(s32), .M_axis(m32), .Err(err32)
    );

    int checks = 0;
    int errors = 0;
    int err8_cnt = 0;
    int err32_cnt = 0;
    int stall_viol = 0;
    logic bp_en = 1'b0;
    logic stall_en = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] held_d;
    logic held_l;

    logic [7:0]  o8_d[$];
    logic        o8_l[$];
    logic        o8_u[$];
    logic        o8_k[$];
    logic [31:0] o32_d[$];
    logic [3:0]  o32_k[$];
    logic        o32_l[$];
    logic        o32_u[$];
    logic [7:0]  pay8[$];

    // Sink ready for the 8-bit DUT, updated just after each rising edge.
    always @(posedge Clk) begin
        #2;
        if (stall_en) m8.tready = 1'b0;
        else if (bp_en) m8.tready = ($urandom_range(0, 99) >= 30);
        else m8.tready = 1'b1;
    end

    // Output collection, hold-stability tracking and Err pulse counting.
    always @(negedge Clk) begin
        if (m8.tvalid && m8.tready) begin
            o8_d.push_back(m8.tdata);
            o8_l.push_back(m8.tlast);
            o8_u.push_back(m8.tuser);
            o8_k.push_back(m8.tkeep);
        end
        if (prev_stall && m8.tvalid && (m8.tdata !== held_d || m8.tlast !== held_l)) stall_viol++;
        prev_stall = m8.tvalid && !m8.tready;
        held_d = m8.tdata;
        held_l = m8.tlast;
        if (err8) err8_cnt++;
        if (m32.tvalid && m32.tready) begin
            o32_d.push_back(m32.tdata);
            o32_k.push_back(m32.tkeep);
            o32_l.push_back(m32.tlast);
            o32_u.push_back(m32.tuser);
        end
        if (err32) err32_cnt++;
    end

    task automatic o8_clear();
        o8_d.delete(); o8_l.delete(); o8_u.delete(); o8_k.delete();
    endtask

    task automatic idle(input int gap);
        if (gap > 0) begin
            repeat ($urandom_range(0, gap)) begin
                @(posedge Clk);
                #1;
            end
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic last, input logic user);
        int t;
        logic rdy;
        s8.tvalid = 1'b1; s8.tdata = d; s8.tkeep = 1'b1; s8.tlast = last; s8.tuser = user;
        t = 0;
        rdy = 1'b0;
        while (!rdy && t < 500) begin
            @(negedge Clk);
            rdy = s8.tready;
            @(posedge Clk);
            #1;
            t++;
        end
        s8.tvalid = 1'b0;
        s8.tlast = 1'b0;
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send8 timeout: tready=%b after %0d cycles, want 1", rdy, t);
        end
    endtask

    task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic last);
        int t;
        logic rdy;
        s32.tvalid = 1'b1; s32.tdata = d; s32.tkeep = k; s32.tlast = last; s32.tuser = 1'b1;
        t = 0;
        rdy = 1'b0;
        while (!rdy && t < 500) begin
            @(negedge Clk);
            rdy = s32.tready;
            @(posedge Clk);
            #1;
            t++;
        end
        s32.tvalid = 1'b0;
        s32.tlast = 1'b0;
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send32 timeout: tready=%b after %0d cycles, want 1", rdy, t);
        end
    endtask

    // Header bytes are 00..2f (key 00..1f, IV 20..2f), then pay8.
    task automatic send_pkt8(input logic user, input int gap);
        for (int i = 0; i < 48; i++) begin
            send8(8'(i), (i == 47) && (pay8.size() == 0), user);
            idle(gap);
        end
        for (int i = 0; i < pay8.size(); i++) begin
            send8(pay8[i], i == pay8.size() - 1, user);
            idle(gap);
        end
    endtask

    task automatic wait_drain8(input int n);
        int t;
        t = 0;
        while (o8_d.size() < n && t < 3000) begin
            @(posedge Clk);
            t++;
        end
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        checks++; if (m8.tvalid !== 1'b0) begin errors++; $display("FAIL reset tvalid: got %b want 0", m8.tvalid); end
        checks++; if (m8.tdata !== 8'h00) begin errors++; $display("FAIL reset tdata: got %h want 00", m8.tdata); end
        checks++; if (m8.tkeep !== 1'b0 || m8.tlast !== 1'b0 || m8.tuser !== 1'b0) begin
            errors++; $display("FAIL reset ctl: got keep=%b last=%b user=%b want 0 0 0", m8.tkeep, m8.tlast, m8.tuser); end
        checks++; if (err8 !== 1'b0 || err32 !== 1'b0) begin errors++; $display("FAIL reset err: got %b %b want 0 0", err8, err32); end
        checks++; if (s8.tready !== 1'b1) begin errors++; $display("FAIL reset s_tready: got %b want 1", s8.tready); end
        checks++; if (m32.tvalid !== 1'b0 || m32.tdata !== 32'h0) begin
            errors++; $display("FAIL reset w32: got v=%b d=%h want 0 00000000", m32.tvalid, m32.tdata); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_enc_short();
        logic [7:0] exp[$];
        int e0;
        o8_clear();
        e0 = err8_cnt;
        pay8 = {8'h61, 8'h62, 8'h63};
        send_pkt8(1'b1, 0);
        wait_drain8(64);
        for (int i = 0; i < 48; i++) exp.push_back(8'(i));
        exp.push_back(8'h61); exp.push_back(8'h62); exp.push_back(8'h63);
        repeat (13) exp.push_back(8'h0d);
        checks++; if (o8_d.size() !== 64) begin errors++; $display("FAIL enc_short count: got %0d want 64", o8_d.size()); end
        for (int i = 0; i < exp.size() && i < o8_d.size(); i++) begin
            checks++;
            if (o8_d[i] !== exp[i] || o8_l[i] !== (i == 63) || o8_u[i] !== 1'b1 || o8_k[i] !== 1'b1) begin
                errors++;
                $display("FAIL enc_short beat %0d: got d=%h l=%b u=%b k=%b want d=%h l=%b u=1 k=1",
                         i, o8_d[i], o8_l[i], o8_u[i], o8_k[i], exp[i], i == 63);
            end
        end
        checks++; if (err8_cnt - e0 !== 0) begin errors++; $display("FAIL enc_short err: got %0d pulses want 0", err8_cnt - e0); end
    endtask

    task automatic test_enc_full();
        logic [7:0] exp[$];
        int e0;
        o8_clear();
        e0 = err8_cnt;
        pay8.delete();
        for (int i = 0; i < 16; i++) pay8.push_back(8'(128 + i));
        send_pkt8(1'b1, 0);
        wait_drain8(80);
        for (int i = 0; i < 48; i++) exp.push_back(8'(i));
        for (int i = 0; i < 16; i++) exp.push_back(8'(128 + i));
        repeat (16) exp.push_back(8'h10);
        checks++; if (o8_d.size() !== 80) begin errors++; $display("FAIL enc_full count: got %0d want 80", o8_d.size()); end
        for (int i = 0; i < exp.size() && i < o8_d.size(); i++) begin
            checks++;
            if (o8_d[i] !== exp[i] || o8_l[i] !== (i == 79) || o8_u[i] !== 1'b1) begin
                errors++;
                $display("FAIL enc_full beat %0d: got d=%h l=%b u=%b want d=%h l=%b u=1",
                         i, o8_d[i], o8_l[i], o8_u[i], exp[i], i == 79);
            end
        end
        checks++; if (err8_cnt - e0 !== 0) begin errors++; $display("FAIL enc_full err: got %0d pulses want 0", err8_cnt - e0); end
    endtask

    task automatic test_w32();
        logic [31:0] exp[$];
        int e0;
        int t;
        e0 = err32_cnt;
        o32_d.delete(); o32_k.delete(); o32_l.delete(); o32_u.delete();
        for (int b = 0; b < 12; b++) begin
            send32({8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)}, 4'hf, 1'b0);
            exp.push_back({8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)});
        end
        send32(32'ha3a2a1a0, 4'hf, 1'b0);
        send32(32'hdeadbea4, 4'b0001, 1'b1);
        exp.push_back(32'ha3a2a1a0);
        exp.push_back(32'h0b0b0ba4);
        exp.push_back(32'h0b0b0b0b);
        exp.push_back(32'h0b0b0b0b);
        t = 0;
        while (o32_d.size() < 16 && t < 500) begin
            @(posedge Clk);
            t++;
        end
        repeat (4) @(posedge Clk);
        #1;
        checks++; if (o32_d.size() !== 16) begin errors++; $display("FAIL w32 count: got %0d want 16", o32_d.size()); end
        for (int i = 0; i < exp.size() && i < o32_d.size(); i++) begin
            checks++;
            if (o32_d[i] !== exp[i] || o32_k[i] !== 4'hf || o32_l[i] !== (i == 15) || o32_u[i] !== 1'b1) begin
                errors++;
                $display("FAIL w32 beat %0d: got d=%h k=%h l=%b u=%b want d=%h k=f l=%b u=1",
                         i, o32_d[i], o32_k[i], o32_l[i], o32_u[i], exp[i], i == 15);
            end
        end
        checks++; if (err32_cnt - e0 !== 0) begin errors++; $display("FAIL w32 err: got %0d pulses want 0", err32_cnt - e0); end
    endtask

    task automatic test_decrypt();
        logic [7:0] exp[$];
        int e0;
        for (int len = 32; len >= 31; len--) begin
            o8_clear();
            exp.delete();
            e0 = err8_cnt;
            pay8.delete();
            for (int i = 0; i < len; i++) pay8.push_back(8'(192 + i));
            send_pkt8(1'b0, 0);
            wait_drain8(48 + len);
            for (int i = 0; i < 48; i++) exp.push_back(8'(i));
            for (int i = 0; i < len; i++) exp.push_back(8'(192 + i));
            checks++;
            if (o8_d.size() !== 48 + len) begin
                errors++; $display("FAIL dec%0d count: got %0d want %0d", len, o8_d.size(), 48 + len);
            end
            for (int i = 0; i < exp.size() && i < o8_d.size(); i++) begin
                checks++;
                if (o8_d[i] !== exp[i] || o8_l[i] !== (i == 47 + len) || o8_u[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL dec%0d beat %0d: got d=%h l=%b u=%b want d=%h l=%b u=0",
                             len, i, o8_d[i], o8_l[i], o8_u[i], exp[i], i == 47 + len);
                end
            end
            checks++;
            if (err8_cnt - e0 !== ((len == 32) ? 0 : 1)) begin
                errors++; $display("FAIL dec%0d err: got %0d pulses want %0d", len, err8_cnt - e0, (len == 32) ? 0 : 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        int v0;
        o8_clear();
        v0 = stall_viol;
        bp_en = 1'b1;
        pay8 = {8'h61, 8'h62, 8'h63};
        send_pkt8(1'b1, 3);
        wait_drain8(64);
        bp_en = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        for (int i = 0; i < 48; i++) exp.push_back(8'(i));
        exp.push_back(8'h61); exp.push_back(8'h62); exp.push_back(8'h63);
        repeat (13) exp.push_back(8'h0d);
        checks++; if (o8_d.size() !== 64) begin errors++; $display("FAIL bp count: got %0d want 64", o8_d.size()); end
        for (int i = 0; i < exp.size() && i < o8_d.size(); i++) begin
            checks++;
            if (o8_d[i] !== exp[i] || o8_l[i] !== (i == 63)) begin
                errors++; $display("FAIL bp beat %0d: got d=%h l=%b want d=%h l=%b", i, o8_d[i], o8_l[i], exp[i], i == 63);
            end
        end
        checks++; if (stall_viol - v0 !== 0) begin errors++; $display("FAIL bp stability: got %0d changes while stalled want 0", stall_viol - v0); end
    endtask

    task automatic test_hdr_tlast();
        logic [7:0] exp[$];
        int e0;
        o8_clear();
        e0 = err8_cnt;
        for (int i = 0; i < 10; i++) send8(8'(i), 1'b0, 1'b1);
        send8(8'd10, 1'b1, 1'b1);
        repeat (4) @(posedge Clk);
        #1;
        checks++; if (o8_d.size() !== 10) begin errors++; $display("FAIL hdr_tlast fwd: got %0d beats want 10", o8_d.size()); end
        checks++; if (err8_cnt - e0 !== 1) begin errors++; $display("FAIL hdr_tlast err: got %0d pulses want 1", err8_cnt - e0); end
        o8_clear();
        pay8 = {8'h41};
        send_pkt8(1'b1, 0);
        wait_drain8(64);
        for (int i = 0; i < 48; i++) exp.push_back(8'(i));
        exp.push_back(8'h41);
        repeat (15) exp.push_back(8'h0f);
        checks++; if (o8_d.size() !== 64) begin errors++; $display("FAIL hdr_restart count: got %0d want 64", o8_d.size()); end
        for (int i = 0; i < exp.size() && i < o8_d.size(); i++) begin
            checks++;
            if (o8_d[i] !== exp[i] || o8_l[i] !== (i == 63)) begin
                errors++; $display("FAIL hdr_restart beat %0d: got d=%h l=%b want d=%h l=%b", i, o8_d[i], o8_l[i], exp[i], i == 63);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        o8_clear();
        for (int i = 0; i < 48; i++) send8(8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send8(8'(112 + i), 1'b0, 1'b1);
        send8(8'h74, 1'b0, 1'b1);
        stall_en = 1'b1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        checks++; if (m8.tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid tvalid: got %b want 0", m8.tvalid); end
        checks++; if (s8.tready !== 1'b1) begin errors++; $display("FAIL rst_mid s_tready: got %b want 1", s8.tready); end
        stall_en = 1'b0;
        @(posedge Clk);
        #1;
        o8_clear();
        pay8 = {8'h61, 8'h62, 8'h63};
        send_pkt8(1'b1, 0);
        wait_drain8(64);
        for (int i = 0; i < 48; i++) exp.push_back(8'(i));
        exp.push_back(8'h61); exp.push_back(8'h62); exp.push_back(8'h63);
        repeat (13) exp.push_back(8'h0d);
        checks++; if (o8_d.size() !== 64) begin errors++; $display("FAIL rst_mid count: got %0d want 64", o8_d.size()); end
        for (int i = 0; i < exp.size() && i < o8_d.size(); i++) begin
            checks++;
            if (o8_d[i] !== exp[i] || o8_l[i] !== (i == 63) || o8_u[i] !== 1'b1) begin
                errors++; $display("FAIL rst_mid beat %0d: got d=%h l=%b u=%b want d=%h l=%b u=1",
                                   i, o8_d[i], o8_l[i], o8_u[i], exp[i], i == 63);
            end
        end
    endtask

    initial begin
        s8.tvalid = 1'b0; s8.tdata = 8'h00; s8.tkeep = 1'b0; s8.tlast = 1'b0; s8.tuser = 1'b0;
        s32.tvalid = 1'b0; s32.tdata = 32'h0; s32.tkeep = 4'h0; s32.tlast = 1'b0; s32.tuser = 1'b0;
        m8.tready = 1'b1;
        m32.tready = 1'b1;
        test_reset();
        test_enc_short();
        test_enc_full();
        test_w32();
        test_decrypt();
        test_backpressure();
        test_hdr_tlast();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cbc_pkcs7_padder.md
Name: aes_cbc_pkcs7_padder

Overview:
- Upstream feeder for the AES-256-CBC iterative core.
- Accepts a host packet on AXI-Stream: key (32 B), then IV (16 B), then payload (any byte length).
- Forwards the packet as the 16-byte-aligned stream the core expects.
- Encrypt packets (tuser=1) get PKCS#7 padding appended. Decrypt packets (tuser=0) pass through and are length-checked.

Parameters:
- AXIS_WIDTH, 8, tdata width in bits on both sides. Legal values: 8, 16, 32, 64, 128. BPB = AXIS_WIDTH/8 bytes per beat.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset: Rst, synchronous, active-high; clock Clk.
- S_axis  axis_if.slave  tdata AXIS_WIDTH / tkeep BPB / tlast 1 / tuser 1  host packet input.
- M_axis  axis_if.master  same widths  aligned stream to the CBC core.
- Err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Byte order: beat k of a block occupies block bits [k*AXIS_WIDTH +: AXIS_WIDTH]; byte 0 is the lowest byte of tdata. tkeep is contiguous from bit 0.
- Output register stage:
  - All M_axis signals are registered.
  - S_axis.tready = (~M_axis.tvalid | M_axis.tready) & (state != ST_PAD).
  - Latency is 1 cycle from input accept to output valid.
  - Full throughput in ST_HEADER and ST_PAYLOAD.
- Reset values: M_axis.tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, Err=0, state=ST_HEADER, all counters 0.
- State ST_HEADER:
  - Forwards 48/BPB beats unchanged; output tlast=0.
  - tuser is captured into mode_reg on the first header beat. Every output beat of the packet carries mode_reg as tuser.
  - Input tlast on a non-final header beat: pulse Err, drop the beat, restart ST_HEADER at beat 0.
  - tlast on the final header beat is an empty payload.
    - Encrypt: go to ST_PAD with pad=16.
    - Decrypt: pulse Err, output that beat with tlast=1, return to ST_HEADER.
  - Otherwise, after the final header beat go to ST_PAYLOAD with block byte offset off=0.
- State ST_PAYLOAD, decrypt:
  - Pass-through; off advances by BPB per beat, mod 16.
  - Input tlast is forwarded as tlast.
  - Err pulses if tlast arrives with off+popcount(tkeep) != 16, or if a non-last beat has a partial tkeep. The beat is still forwarded.
  - Return to ST_HEADER after tlast.
- State ST_PAYLOAD, encrypt:
  - Non-last beats: pass-through. A partial tkeep on a non-last beat pulses Err; the beat is forwarded as given.
  - Last beat: n = popcount(tkeep), pad = 16 - ((off+n) mod 16), range 1..16.
  - The output beat has its missing bytes filled with the byte value pad, and tkeep is all ones.
  - If off+BPB == 16 and n < BPB, the block completes in this beat: output tlast=1, return to ST_HEADER.
  - Otherwise output tlast=0 and go to ST_PAD holding pad.
- State ST_PAD:
  - Emits beats of tdata = {BPB{pad}} with tkeep all ones until the block ends (off wraps to 0).
  - The final beat has tlast=1; then return to ST_HEADER.
  - S_axis.tready=0 throughout.
  - A full pad block is 16/BPB beats of 8'h10.
- Encrypt output byte count is therefore 48 + 16*ceil((L+1)/16) for payload length L.
- Backpressure: the output register holds while M_axis.tvalid & ~M_axis.tready. tdata/tkeep/tlast/tuser are stable while tvalid is high.
- Reset mid-packet: the packet is discarded, the output register is cleared, and the next accepted beat is a header beat 0.
- Counters: hdr_cnt range 0..48/BPB-1. off is a 4-bit byte offset (wraps mod 16).

Decomposition:
- aes_defines.svh: AES_BLOCK_SIZE (128), AES_BLOCK_BYTES (16), AES_256_KEY_BYTES (32), AES_IV_BYTES (16).
- Package aes_pkg: state enum (ST_HEADER, ST_PAYLOAD, ST_PAD, one-hot) and a popcount function for tkeep.
- Sub-module aes_pkcs7_fill: combinational. Inputs: a beat, tkeep, and the pad byte. Output: the filled beat. Shared with the future unpadder.

Test Plan:
- W=8, encrypt: key 00..1f, IV 20..2f, payload 61 62 63 (3 B) -> 3 payload beats, then 13 beats of 8'h0d; tlast on the 13th pad beat; 64 output beats total; Err=0.
- W=8, encrypt, 16-byte payload -> 16 payload beats, then 16 beats of 8'h10 with tlast on the last; output 80 beats.
- W=32, encrypt: payload 5 B (second beat tkeep=4'b0001) -> second payload beat becomes {0b,0b,0b,xx} with tkeep=4'hf; 2 PAD beats of 32'h0b0b0b0b; tlast on the last.
- W=8, decrypt: payload 32 B with tlast on byte 32 -> byte-exact pass-through, tuser=0, Err=0. Repeat with tlast on byte 31 -> Err pulses once, all beats forwarded.
- W=8, encrypt: random M_axis.tready at 30% and tvalid gaps -> the output sequence equals the no-backpressure run; tdata stable while stalled; no beat lost or duplicated.
- Rst asserted for one cycle mid-payload -> M_axis.tvalid=0 next cycle; a following clean packet is processed correctly from header beat 0. Also: tlast on header beat 10 -> Err pulse, that beat is dropped.
